// File: rtl/smc_pkg.sv
// ============================================================================
//  Module   : smc_pkg
//  Brief    : Shared constants, mode encodings and FSM state type for smc_serial.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package smc_pkg;

    localparam int NUM_TR = 6;
    localparam int CNT_W  = 3;
    localparam int N_W    = 7;
    localparam int OUT_W  = 10;

    localparam int   MODE_ID_BIT    = 0;
    localparam int   MODE_LARGE_BIT = 1;
    localparam logic MODE_ID        = 1'b1;
    localparam logic MODE_GM        = 1'b0;
    localparam logic MODE_LARGE     = 1'b1;
    localparam logic MODE_SMALL     = 1'b0;

    localparam logic [OUT_W-1:0] WEIGHT_A = 10'd3;
    localparam logic [OUT_W-1:0] WEIGHT_B = 10'd4;
    localparam logic [OUT_W-1:0] WEIGHT_C = 10'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SUM  = 2'd2,
        OUT  = 2'd3
    } state_e;

endpackage

`default_nettype wire

// File: rtl/smc_tr_calc.sv
// ============================================================================
//  Module   : smc_tr_calc
//  Brief    : Combinational per-transistor drain current / transconductance.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module smc_tr_calc
    import smc_pkg::*;
(
    input  logic [2:0]     vgs_i,
    input  logic [2:0]     vds_i,
    input  logic [2:0]     w_i,
    input  logic           id_sel_i,
    output logic [N_W-1:0] n_o
);

    logic [2:0] vt;
    logic       cutoff;
    logic       triode;
    logic [9:0] vt10;
    logic [9:0] vds10;
    logic [9:0] w10;
    logic [9:0] id_core;
    logic [9:0] gm_core;
    logic [9:0] prod;

    always_comb begin
        vt      = vgs_i - 3'd1;
        cutoff  = (vgs_i <= 3'd1);
        triode  = (vt > vds_i);
        vt10    = {7'd0, vt};
        vds10   = {7'd0, vds_i};
        w10     = {7'd0, w_i};
        // Triode core stays non-negative because vt > vds in that region.
        id_core = triode ? (((vt10 * vds10) << 1) - (vds10 * vds10)) : (vt10 * vt10);
        gm_core = triode ? vds10 : vt10;
        prod    = id_sel_i ? (id_core * w10) : ((gm_core * w10) << 1);
        n_o     = cutoff ? '0 : N_W'(prod / 10'd3);
    end

endmodule

`default_nettype wire

// File: rtl/smc_serial.sv
// ============================================================================
//  Module   : smc_serial
//  Brief    : Streamed SMC job: per-beat calc, sorted insertion, weighted sum.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module smc_serial
    import smc_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       mode,
    input  logic [2:0]       vgs,
    input  logic [2:0]       vds,
    input  logic [2:0]       w,
    output logic [OUT_W-1:0] out,
    output logic             out_valid
);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [1:0]           mode_q, mode_d;
    logic [OUT_W-1:0]     out_q, out_d;
    logic [N_W-1:0]       list_q [NUM_TR];
    logic [N_W-1:0]       list_d [NUM_TR];
    logic [N_W-1:0]       ins    [NUM_TR];
    logic                 gt     [NUM_TR];
    logic [N_W-1:0]       n;
    logic                 id_sel;
    logic                 accept;
    logic [OUT_W-1:0]     wa, wb, wc;

    assign in_ready  = (state_q == IDLE) || (state_q == LOAD);
    assign out_valid = (state_q == OUT);
    assign out       = out_q;
    assign accept    = in_valid && in_ready;

    // The first beat is converted before mode is latched, so use the live bus.
    assign id_sel = (state_q == IDLE) ? mode[MODE_ID_BIT] : mode_q[MODE_ID_BIT];

    smc_tr_calc u_calc (
        .vgs_i    (vgs),
        .vds_i    (vds),
        .w_i      (w),
        .id_sel_i (id_sel),
        .n_o      (n)
    );

    // Descending list: n lands at the first slot it beats, lower entries shift down.
    always_comb begin
        for (int i = 0; i < NUM_TR; i++) begin
            gt[i] = (n > list_q[i]);
        end
        ins[0] = gt[0] ? n : list_q[0];
        for (int i = 1; i < NUM_TR; i++) begin
            if (!gt[i])          ins[i] = list_q[i];
            else if (gt[i-1])    ins[i] = list_q[i-1];
            else                 ins[i] = n;
        end
    end

    always_comb begin
        if (mode_q[MODE_LARGE_BIT] == MODE_LARGE) begin
            wa = {3'd0, list_q[0]};
            wb = {3'd0, list_q[1]};
            wc = {3'd0, list_q[2]};
        end else begin
            wa = {3'd0, list_q[3]};
            wb = {3'd0, list_q[4]};
            wc = {3'd0, list_q[5]};
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        out_d   = out_q;
        list_d  = list_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    mode_d  = mode;
                    list_d  = ins;
                    cnt_d   = CNT_W'(1);
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (accept) begin
                    list_d = ins;
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(NUM_TR - 1)) state_d = SUM;
                end
            end
            SUM: begin
                if (mode_q[MODE_ID_BIT] == MODE_ID)
                    out_d = WEIGHT_A * wa + WEIGHT_B * wb + WEIGHT_C * wc;
                else
                    out_d = wa + wb + wc;
                state_d = OUT;
            end
            OUT: begin
                cnt_d   = '0;
                for (int i = 0; i < NUM_TR; i++) list_d[i] = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mode_q  <= '0;
            out_q   <= '0;
            for (int i = 0; i < NUM_TR; i++) list_q[i] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            out_q   <= out_d;
            for (int i = 0; i < NUM_TR; i++) list_q[i] <= list_d[i];
        end
    end

endmodule

`default_nettype wire
